// File: rtl/lt24_frame_scheduler_if.sv
// Signal bundle between the frame scheduler, the framebuffer read port and the LT24 driver.
// master = scheduler side, slave = environment (RAM, driver, requesters).
interface lt24_frame_scheduler_if #(
    parameter int ADDR_W = 17
);
    logic              refresh_req;
    logic              clear_req;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              lcd_initialized;
    logic              lcd_done;
    logic              lcd_print;
    logic [15:0]       lcd_pixel;
    logic              busy;
    logic              frame_done;

    modport master (
        input  refresh_req, clear_req, fb_data, lcd_initialized, lcd_done,
        output fb_rd_en, fb_addr, lcd_print, lcd_pixel, busy, frame_done
    );

    modport slave (
        output refresh_req, clear_req, fb_data, lcd_initialized, lcd_done,
        input  fb_rd_en, fb_addr, lcd_print, lcd_pixel, busy, frame_done
    );
endinterface

// File: rtl/lt24_frame_scheduler.sv
// Streams a whole frame into the LT24 driver, one pixel per print/done handshake,
// sourcing pixels from the framebuffer (refresh) or a constant colour (clear).
module lt24_frame_scheduler #(
    parameter int          H_RES       = 240,
    parameter int          V_RES       = 320,
    parameter int          ADDR_W      = 17,
    parameter logic [15:0] CLEAR_COLOR = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    lt24_frame_scheduler_if.master bus
);

    localparam int                NPIX = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRINT, WAIT_DONE} state_t;
    typedef enum logic {MODE_REF, MODE_CLR} mode_t;

    state_t            state;
    mode_t             mode;
    logic              pend_ref;
    logic              pend_clr;
    logic [ADDR_W-1:0] cnt;
    logic              start_clr;
    logic              start_ref;

    // Clear has priority; the losing request simply stays pending.
    always_comb begin
        start_clr = 1'b0;
        start_ref = 1'b0;
        if (state == IDLE && bus.lcd_initialized) begin
            start_clr = pend_clr;
            start_ref = !pend_clr && pend_ref;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            mode           <= MODE_REF;
            pend_ref       <= 1'b0;
            pend_clr       <= 1'b0;
            cnt            <= '0;
            bus.fb_rd_en   <= 1'b0;
            bus.fb_addr    <= '0;
            bus.lcd_print  <= 1'b0;
            bus.lcd_pixel  <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            pend_clr       <= (pend_clr & ~start_clr) | bus.clear_req;
            pend_ref       <= (pend_ref & ~start_ref) | bus.refresh_req;
            bus.frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_clr || start_ref) begin
                        mode     <= start_clr ? MODE_CLR : MODE_REF;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= FETCH;
                        if (start_ref) begin
                            bus.fb_rd_en <= 1'b1;
                            bus.fb_addr  <= '0;
                        end
                    end
                end

                // A read is normally issued on entry; if the LCD went uninitialized
                // at the last handshake we wait here and issue it on recovery.
                FETCH: begin
                    if (bus.fb_rd_en) begin
                        bus.fb_rd_en <= 1'b0;
                        state        <= LOAD;
                    end else if (bus.lcd_initialized) begin
                        if (mode == MODE_CLR) begin
                            bus.lcd_pixel <= CLEAR_COLOR;
                            bus.lcd_print <= 1'b1;
                            state         <= PRINT;
                        end else begin
                            bus.fb_rd_en <= 1'b1;
                            bus.fb_addr  <= cnt;
                        end
                    end
                end

                LOAD: begin
                    bus.lcd_pixel <= bus.fb_data;
                    bus.lcd_print <= 1'b1;
                    state         <= PRINT;
                end

                PRINT: state <= WAIT_DONE;

                WAIT_DONE: begin
                    if (bus.lcd_done) begin
                        bus.lcd_print <= 1'b0;
                        if (cnt == LAST) begin
                            bus.frame_done <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= FETCH;
                            if (mode == MODE_REF && bus.lcd_initialized) begin
                                bus.fb_rd_en <= 1'b1;
                                bus.fb_addr  <= cnt + 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lt24_frame_scheduler.sv
// Directed bench for lt24_frame_scheduler with framebuffer and LCD driver models
// and a queue scoreboard of expected addresses and printed pixels.
module tb_lt24_frame_scheduler;

    localparam int ADDR_W = 4;
    localparam int NPIX   = 8;

    logic clk;
    logic reset;

    lt24_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    lt24_frame_scheduler #(
        .H_RES      (4),
        .V_RES      (2),
        .ADDR_W     (ADDR_W),
        .CLEAR_COLOR(16'hFFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_pix[$];
    logic [15:0] obs_pix[$];
    int          exp_addr[$];
    int          obs_addr[$];
    int          fd_count = 0;
    int          fd_bad   = 0;
    int          hold_err = 0;
    int          long_pix = -1;
    int          spur_req = 0;

    // Environment: monitor, 1-cycle-latency framebuffer, and driver model.
    initial begin : env
        logic        print_q;
        logic        fd_q;
        logic        rd_q;
        logic [ADDR_W-1:0] addr_q;
        logic [15:0] held;
        int          wait_cnt;
        int          pix_idx;
        int          spur_ack;
        print_q = 1'b0; fd_q = 1'b0; rd_q = 1'b0; addr_q = '0; held = '0;
        wait_cnt = 0; pix_idx = 0; spur_ack = 0;
        bus.lcd_done = 1'b0;
        bus.fb_data  = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (bus.fb_rd_en === 1'b1) obs_addr.push_back(32'(bus.fb_addr));
            if (bus.lcd_print === 1'b1 && !print_q) obs_pix.push_back(bus.lcd_pixel);
            if (bus.lcd_print === 1'b1 && print_q && bus.lcd_pixel !== held) hold_err++;
            if (bus.lcd_print === 1'b1) held = bus.lcd_pixel;
            if (bus.frame_done === 1'b1) begin
                fd_count++;
                if (bus.lcd_done !== 1'b1 || bus.busy !== 1'b0 || fd_q) fd_bad++;
            end
            fd_q = (bus.frame_done === 1'b1);

            bus.fb_data = rd_q ? (16'(addr_q) + 16'h0100) : 16'hDEAD;
            rd_q   = (bus.fb_rd_en === 1'b1);
            addr_q = bus.fb_addr;

            if (!reset) begin
                wait_cnt     = 0;
                pix_idx      = 0;
                bus.lcd_done = 1'b0;
            end else begin
                bus.lcd_done = 1'b0;
                if (bus.lcd_print === 1'b1 && !print_q) begin
                    wait_cnt = (pix_idx == long_pix) ? 20 : 3;
                    pix_idx++;
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) bus.lcd_done = 1'b1;
                end
                if (spur_req != spur_ack) begin
                    bus.lcd_done = 1'b1;
                    spur_ack     = spur_req;
                end
                if (bus.frame_done === 1'b1) pix_idx = 0;
            end
            print_q = (bus.lcd_print === 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  32'(bus.fb_rd_en),   32'd0);
        check({tag, "_addr"},   32'(bus.fb_addr),    32'd0);
        check({tag, "_print"},  32'(bus.lcd_print),  32'd0);
        check({tag, "_pixel"},  32'(bus.lcd_pixel),  32'd0);
        check({tag, "_busy"},   32'(bus.busy),       32'd0);
        check({tag, "_fdone"},  32'(bus.frame_done), 32'd0);
    endtask

    task automatic push_ref(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_pix.push_back(16'h0100 + 16'(i));
        end
    endtask

    task automatic push_clr(input int n);
        for (int i = 0; i < n; i++) exp_pix.push_back(16'hFFFF);
    endtask

    task automatic pulse_refresh();
        bus.refresh_req = 1'b1;
        step(1);
        bus.refresh_req = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n;
        n = 0;
        while (fd_count < target && n < budget) begin
            step(1);
            n++;
        end
        check("frame_done_count", 32'(fd_count), 32'(target));
    endtask

    task automatic wait_pix(input int target, input int budget);
        int n;
        n = 0;
        while (obs_pix.size() < target && n < budget) begin
            step(1);
            n++;
        end
        check("prints_reached", 32'(obs_pix.size()), 32'(target));
    endtask

    task automatic drain(input string tag);
        while (exp_pix.size() > 0) begin
            logic [15:0] e;
            e = exp_pix.pop_front();
            if (obs_pix.size() > 0) check({tag, "_pixel"}, 32'(obs_pix.pop_front()), 32'(e));
            else check({tag, "_pixel_missing"}, 32'hFFFF_FFFF, 32'(e));
        end
        check({tag, "_extra_prints"}, 32'(obs_pix.size()), 32'd0);
        while (exp_addr.size() > 0) begin
            int e;
            e = exp_addr.pop_front();
            if (obs_addr.size() > 0) check({tag, "_addr"}, 32'(obs_addr.pop_front()), 32'(e));
            else check({tag, "_addr_missing"}, 32'hFFFF_FFFF, 32'(e));
        end
        check({tag, "_extra_reads"}, 32'(obs_addr.size()), 32'd0);
        obs_pix.delete();
        obs_addr.delete();
    endtask

    initial begin : main
        int fd_base;
        reset               = 1'b0;
        bus.refresh_req     = 1'b0;
        bus.clear_req       = 1'b0;
        bus.lcd_initialized = 1'b0;

        // Reset and uninitialized LCD
        step(2);
        check_reset_outputs("reset");
        reset = 1'b1;
        step(1);
        pulse_refresh();
        step(5);
        check("uninit_busy", 32'(bus.busy), 32'd0);
        check("uninit_reads", 32'(obs_addr.size()), 32'd0);
        push_ref(NPIX);
        bus.lcd_initialized = 1'b1;
        step(1);
        check("start_busy", 32'(bus.busy), 32'd1);
        wait_fd(1, 400);
        drain("refresh1");
        check("refresh1_fd_shape", 32'(fd_bad), 32'd0);
        check("refresh1_busy_after", 32'(bus.busy), 32'd0);

        // Clear frame
        bus.clear_req = 1'b1;
        step(1);
        bus.clear_req = 1'b0;
        push_clr(NPIX);
        wait_fd(2, 400);
        drain("clear");

        // Priority: clear first, repeated refresh absorbed
        bus.clear_req   = 1'b1;
        bus.refresh_req = 1'b1;
        step(1);
        bus.clear_req   = 1'b0;
        bus.refresh_req = 1'b0;
        push_clr(NPIX);
        push_ref(NPIX);
        step(10);
        check("prio_busy_mid_clear", 32'(bus.busy), 32'd1);
        pulse_refresh();
        wait_fd(4, 800);
        step(60);
        check("prio_no_extra_frame", 32'(fd_count), 32'd4);
        check("prio_idle_busy", 32'(bus.busy), 32'd0);
        drain("prio");
        check("prio_fd_shape", 32'(fd_bad), 32'd0);

        // Handshake hold with a slow done on pixel 3
        long_pix = 3;
        pulse_refresh();
        push_ref(NPIX);
        wait_fd(5, 600);
        long_pix = -1;
        drain("hold");
        check("hold_stable", 32'(hold_err), 32'd0);

        // Spurious done while idle
        fd_base = fd_count;
        spur_req++;
        step(6);
        check("spur_busy", 32'(bus.busy), 32'd0);
        check("spur_print", 32'(bus.lcd_print), 32'd0);
        check("spur_reads", 32'(obs_addr.size()), 32'd0);
        check("spur_fd", 32'(fd_count), 32'(fd_base));

        // Abort by reset during pixel 5
        pulse_refresh();
        push_ref(6);
        wait_pix(6, 400);
        reset = 1'b0;
        step(1);
        check_reset_outputs("abort");
        reset = 1'b1;
        step(30);
        check("abort_no_fd", 32'(fd_count), 32'(fd_base));
        check("abort_busy", 32'(bus.busy), 32'd0);
        drain("abort");
        pulse_refresh();
        push_ref(NPIX);
        wait_fd(fd_base + 1, 400);
        drain("restart");

        // Stall on lcd_initialized drop during pixel 2
        pulse_refresh();
        push_ref(NPIX);
        wait_pix(3, 400);
        bus.lcd_initialized = 1'b0;
        step(15);
        check("stall_prints", 32'(obs_pix.size()), 32'd3);
        check("stall_reads", 32'(obs_addr.size()), 32'd3);
        check("stall_print", 32'(bus.lcd_print), 32'd0);
        check("stall_busy", 32'(bus.busy), 32'd1);
        bus.lcd_initialized = 1'b1;
        wait_fd(fd_base + 2, 400);
        drain("stall");
        check("final_fd_shape", 32'(fd_bad), 32'd0);
        check("final_hold", 32'(hold_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
